// File: rtl/alu_req_arbiter_pkg.sv
// Shared constants, opcode encoding and FSM state type for the shared-ALU arbiter.
package alu_pkg;

  localparam int DATA_W = 4;
  localparam int OP_W   = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_NOT = 3'd4
  } alu_op_e;

  localparam logic [OP_W-1:0] MAX_OP = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Opcodes above MAX_OP still reach the ALU but are reported as errors.
  function automatic logic op_illegal(input logic [OP_W-1:0] op);
    return (op > MAX_OP);
  endfunction

endpackage

// File: rtl/alu_req_arbiter_if.sv
// Request, response and ALU-side signals of the shared-ALU arbiter.
interface alu_req_arbiter_if;
  import alu_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [OP_W-1:0]   req0_op;
  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [OP_W-1:0]   req1_op;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_zero;
  logic              rsp_err;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_sel;
  logic [DATA_W-1:0] alu_out;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp_ready, alu_out,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err,
    output alu_a, alu_b, alu_sel
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp_ready, alu_out,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err,
    input  alu_a, alu_b, alu_sel
  );

endinterface

// File: rtl/alu_req_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: on a tie the requester that did not win last time is granted.
module rr_arb2 (
  input  logic [1:0] i_valid,
  input  logic       i_last_grant,
  input  logic       i_enable,
  output logic [1:0] o_grant
);

  // One-hot grant, forced to zero while disabled
  always_comb begin
    o_grant = 2'b00;
    if (i_enable) begin
      o_grant[0] = i_valid[0] & (~i_valid[1] | i_last_grant);
      o_grant[1] = i_valid[1] & (~i_valid[0] | ~i_last_grant);
    end else begin
      o_grant = 2'b00;
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one combinational ALU between two requesters: arbitrate, issue, capture, respond.
module alu_req_arbiter
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  alu_req_arbiter_if.slave  bus
);

  state_e            r_state;
  state_e            w_next;
  logic              r_last_grant;
  logic              r_id;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [OP_W-1:0]   r_alu_sel;
  logic              r_rsp_valid;
  logic              r_rsp_id;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_zero;
  logic              r_rsp_err;
  logic [1:0]        w_grant;
  logic              w_hs;
  logic              w_id;

  rr_arb2 u_arb (
    .i_valid      ({bus.req1_valid, bus.req0_valid}),
    .i_last_grant (r_last_grant),
    .i_enable     (r_state == ST_IDLE),
    .o_grant      (w_grant)
  );

  assign w_hs           = w_grant[0] | w_grant[1];
  assign w_id           = w_grant[1];
  assign bus.req0_ready = w_grant[0];
  assign bus.req1_ready = w_grant[1];

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_hs) begin
          w_next = ST_EXEC;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_EXEC: w_next = ST_RESP;
      ST_RESP: begin
        if (bus.rsp_ready) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_RESP;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ALU input bus and arbitration pointer, updated only on an accepted request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_a      <= {DATA_W{1'b0}};
      r_alu_b      <= {DATA_W{1'b0}};
      r_alu_sel    <= {OP_W{1'b0}};
      r_id         <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (w_hs) begin
      r_alu_a      <= w_id ? bus.req1_a  : bus.req0_a;
      r_alu_b      <= w_id ? bus.req1_b  : bus.req0_b;
      r_alu_sel    <= w_id ? bus.req1_op : bus.req0_op;
      r_id         <= w_id;
      r_last_grant <= w_id;
    end
  end

  // Response register: captured in EXEC, held until the consumer accepts it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= {DATA_W{1'b0}};
      r_rsp_zero  <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= r_id;
      r_rsp_data  <= bus.alu_out;
      r_rsp_zero  <= (bus.alu_out == {DATA_W{1'b0}});
      r_rsp_err   <= op_illegal(r_alu_sel);
    end else if ((r_state == ST_RESP) && bus.rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_sel   = r_alu_sel;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_zero  = r_rsp_zero;
  assign bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed self-checking bench for alu_req_arbiter with a behavioural ALU on the ALU bus.
module tb_alu_req_arbiter;
  import alu_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  alu_req_arbiter_if bus ();

  alu_req_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // External ALU: illegal opcodes yield zero
  always_comb begin
    case (bus.alu_sel)
      3'd0:    bus.alu_out = bus.alu_a + bus.alu_b;
      3'd1:    bus.alu_out = bus.alu_a - bus.alu_b;
      3'd2:    bus.alu_out = bus.alu_a & bus.alu_b;
      3'd3:    bus.alu_out = bus.alu_a | bus.alu_b;
      3'd4:    bus.alu_out = ~bus.alu_a;
      default: bus.alu_out = 4'h0;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int id, input logic v, input logic [3:0] a,
                         input logic [3:0] b, input logic [2:0] op);
    if (id == 0) begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    end else begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    end
  endtask

  task automatic wait_ready(input int id, input string tag);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = (id == 0) ? bus.req0_ready : bus.req1_ready;
    end
    check_eq({tag, "_ready"}, got, 1);
  endtask

  task automatic run_op(input int id, input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] op, input logic [3:0] exp_data,
                        input logic exp_zero, input logic exp_err, input string tag);
    @(posedge clk); #1;
    set_req(id, 1'b1, a, b, op);
    wait_ready(id, tag);
    @(posedge clk); #1;
    set_req(id, 1'b0, a, b, op);
    @(negedge clk);
    check_eq({tag, "_alu_a"}, bus.alu_a, a);
    check_eq({tag, "_alu_sel"}, bus.alu_sel, op);
    check_eq({tag, "_vld_early"}, bus.rsp_valid, 0);
    @(negedge clk);
    check_eq({tag, "_vld"}, bus.rsp_valid, 1);
    check_eq({tag, "_data"}, bus.rsp_data, exp_data);
    check_eq({tag, "_id"}, bus.rsp_id, id);
    check_eq({tag, "_zero"}, bus.rsp_zero, exp_zero);
    check_eq({tag, "_err"}, bus.rsp_err, exp_err);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus.rsp_ready = 1'b1;
    set_req(0, 1'b0, 4'h0, 4'h0, 3'd0);
    set_req(1, 1'b0, 4'h0, 4'h0, 3'd0);

    #12;
    check_eq("rst_alu_a", bus.alu_a, 0);
    check_eq("rst_alu_b", bus.alu_b, 0);
    check_eq("rst_alu_sel", bus.alu_sel, 0);
    check_eq("rst_vld", bus.rsp_valid, 0);
    check_eq("rst_data", bus.rsp_data, 0);
    check_eq("rst_rdy0", bus.req0_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_op(0, 4'd3, 4'd4, OP_ADD, 4'd7, 1'b0, 1'b0, "add");
    @(negedge clk);
    check_eq("add_vld_clr", bus.rsp_valid, 0);
    check_eq("idle_hold_a", bus.alu_a, 3);

    run_op(1, 4'd2, 4'd5, OP_SUB, 4'hD, 1'b0, 1'b0, "sub_wrap");
    run_op(1, 4'd5, 4'd5, OP_SUB, 4'h0, 1'b1, 1'b0, "sub_zero");

    // Both requesters continuously valid: grants alternate, one every 3 cycles
    @(posedge clk); #1;
    set_req(0, 1'b1, 4'hA, 4'h0, OP_NOT);
    set_req(1, 1'b1, 4'hA, 4'h0, OP_NOT);
    for (int k = 0; k < 4; k++) begin
      if (k == 0) begin
        for (int w = 0; w < 20 && !(bus.req0_ready || bus.req1_ready); w++) @(negedge clk);
      end else begin
        @(negedge clk);
      end
      check_eq("fair_gap", bus.req0_ready | bus.req1_ready, 1);
      check_eq("fair_onehot", bus.req0_ready & bus.req1_ready, 0);
      check_eq("fair_id", bus.req1_ready, k % 2);
      @(negedge clk);
      @(negedge clk);
      check_eq("fair_vld", bus.rsp_valid, 1);
      check_eq("fair_rsp_id", bus.rsp_id, k % 2);
      check_eq("fair_data", bus.rsp_data, 4'h5);
    end
    set_req(0, 1'b0, 4'h0, 4'h0, 3'd0);
    set_req(1, 1'b0, 4'h0, 4'h0, 3'd0);

    // Backpressure with requester 1 waiting
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    set_req(0, 1'b1, 4'hC, 4'hA, OP_AND);
    wait_ready(0, "bp");
    @(posedge clk); #1;
    set_req(0, 1'b0, 4'hC, 4'hA, OP_AND);
    set_req(1, 1'b1, 4'h5, 4'hA, OP_OR);
    @(negedge clk);
    check_eq("bp_exec_rdy1", bus.req1_ready, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_eq("bp_vld", bus.rsp_valid, 1);
      check_eq("bp_data", bus.rsp_data, 4'h8);
      check_eq("bp_id", bus.rsp_id, 0);
      check_eq("bp_zero", bus.rsp_zero, 0);
      check_eq("bp_rdy0", bus.req0_ready, 0);
      check_eq("bp_rdy1", bus.req1_ready, 0);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_rel_vld", bus.rsp_valid, 1);
    @(negedge clk);
    check_eq("bp_next_grant", bus.req1_ready, 1);
    @(posedge clk); #1;
    set_req(1, 1'b0, 4'h5, 4'hA, OP_OR);
    @(negedge clk);
    @(negedge clk);
    check_eq("bp_or_data", bus.rsp_data, 4'hF);
    check_eq("bp_or_id", bus.rsp_id, 1);

    run_op(0, 4'd3, 4'd1, 3'd6, 4'h0, 1'b1, 1'b1, "illegal");

    // Async reset while in EXEC; pointer was left at requester 0
    @(posedge clk); #1;
    set_req(0, 1'b1, 4'd7, 4'd9, OP_ADD);
    wait_ready(0, "rexec");
    @(posedge clk); #1;
    set_req(0, 1'b0, 4'd7, 4'd9, OP_ADD);
    #3;
    check_eq("rexec_pre_a", bus.alu_a, 7);
    rst = 1'b1;
    #1;
    check_eq("rexec_alu_a", bus.alu_a, 0);
    check_eq("rexec_alu_b", bus.alu_b, 0);
    check_eq("rexec_alu_sel", bus.alu_sel, 0);
    check_eq("rexec_vld", bus.rsp_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    set_req(0, 1'b1, 4'd1, 4'd1, OP_ADD);
    set_req(1, 1'b1, 4'd2, 4'd2, OP_ADD);
    @(negedge clk);
    check_eq("rexec_first_rdy0", bus.req0_ready, 1);
    check_eq("rexec_first_rdy1", bus.req1_ready, 0);
    @(posedge clk); #1;
    set_req(0, 1'b0, 4'd1, 4'd1, OP_ADD);
    set_req(1, 1'b0, 4'd2, 4'd2, OP_ADD);
    @(negedge clk);
    @(negedge clk);
    check_eq("rresp_pre_vld", bus.rsp_valid, 1);
    check_eq("rresp_pre_data", bus.rsp_data, 2);
    #1;
    rst = 1'b1;
    #1;
    check_eq("rresp_vld", bus.rsp_valid, 0);
    check_eq("rresp_data", bus.rsp_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
